// File: rtl/uart.sv
// Fixed-baud 8N1 UART: 2-flop synchronized receiver plus a transmitter that echoes each valid byte.
// A 1-entry last-wins pending register sits between the receiver and the transmitter.
module uart #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       tx,
    output logic [7:0] rx_byte,
    output logic       byte_read
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CW           = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} rx_state_t;
    typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;

    logic            rx_meta_q, rxs_q;
    rx_state_t       rx_state_q, rx_state_d;
    logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic [7:0]      byte_q, byte_d;
    logic            byte_read_q, byte_read_d;
    logic            pend_q, pend_d;
    logic [7:0]      pend_byte_q, pend_byte_d;
    tx_state_t       tx_state_q, tx_state_d;
    logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
    logic [2:0]      tx_bit_q, tx_bit_d;
    logic [7:0]      tx_shift_q, tx_shift_d;
    logic            tx_q, tx_d;
    logic            take_s;

    // Receiver next state: mid-bit sampling driven by a counter that reloads on every state change.
    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q + CW'(1);
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        byte_d      = byte_q;
        byte_read_d = 1'b0;
        case (rx_state_q)
            IDLE: begin
                rx_cnt_d = '0;
                if (!rxs_q) begin
                    rx_state_d = START;
                    rx_bit_d   = 3'd0;
                end else begin
                    rx_state_d = IDLE;
                end
            end
            START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = rxs_q ? IDLE : DATA;
                end else begin
                    rx_state_d = START;
                end
            end
            DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d             = '0;
                    rx_shift_d[rx_bit_q] = rxs_q;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_state_d = DATA;
                end
            end
            STOP: begin
                // Returning to IDLE at mid-stop lets a back-to-back start bit be seen.
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d = '0;
                    if (rxs_q) begin
                        byte_d      = rx_shift_q;
                        byte_read_d = 1'b1;
                        rx_state_d  = IDLE;
                    end else begin
                        rx_state_d = WAIT_IDLE;
                    end
                end else begin
                    rx_state_d = STOP;
                end
            end
            WAIT_IDLE: begin
                rx_cnt_d   = '0;
                rx_state_d = rxs_q ? IDLE : WAIT_IDLE;
            end
            default: begin
                rx_state_d = IDLE;
                rx_cnt_d   = '0;
            end
        endcase
    end

    // Transmitter next state; a pending byte chains straight from the stop bit so echoes never drift.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + CW'(1);
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_d       = tx_q;
        take_s     = 1'b0;
        case (tx_state_q)
            T_IDLE: begin
                tx_cnt_d = '0;
                if (pend_q) begin
                    take_s     = 1'b1;
                    tx_shift_d = pend_byte_q;
                    tx_state_d = T_START;
                    tx_d       = 1'b0;
                end else begin
                    tx_d = 1'b1;
                end
            end
            T_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = 3'd0;
                    tx_state_d = T_DATA;
                    tx_d       = tx_shift_q[0];
                end else begin
                    tx_d = 1'b0;
                end
            end
            T_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = T_STOP;
                        tx_d       = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = {1'b1, tx_shift_q[7:1]};
                        tx_d       = tx_shift_q[1];
                    end
                end else begin
                    tx_d = tx_shift_q[0];
                end
            end
            T_STOP: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (pend_q) begin
                        take_s     = 1'b1;
                        tx_shift_d = pend_byte_q;
                        tx_state_d = T_START;
                        tx_d       = 1'b0;
                    end else begin
                        tx_state_d = T_IDLE;
                        tx_d       = 1'b1;
                    end
                end else begin
                    tx_d = 1'b1;
                end
            end
            default: begin
                tx_state_d = T_IDLE;
                tx_cnt_d   = '0;
                tx_d       = 1'b1;
            end
        endcase
        pend_d      = byte_read_d | (pend_q & ~take_s);
        pend_byte_d = byte_read_d ? rx_shift_q : pend_byte_q;
    end

    // State registers, synchronizer and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q   <= 1'b1;
            rxs_q       <= 1'b1;
            rx_state_q  <= IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= 3'd0;
            rx_shift_q  <= 8'h00;
            byte_q      <= 8'h00;
            byte_read_q <= 1'b0;
            pend_q      <= 1'b0;
            pend_byte_q <= 8'h00;
            tx_state_q  <= T_IDLE;
            tx_cnt_q    <= '0;
            tx_bit_q    <= 3'd0;
            tx_shift_q  <= 8'h00;
            tx_q        <= 1'b1;
        end else begin
            rx_meta_q   <= rx;
            rxs_q       <= rx_meta_q;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            byte_q      <= byte_d;
            byte_read_q <= byte_read_d;
            pend_q      <= pend_d;
            pend_byte_q <= pend_byte_d;
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            tx_q        <= tx_d;
        end
    end

    assign tx        = tx_q;
    assign rx_byte   = byte_q;
    assign byte_read = byte_read_q;
endmodule

// File: tb/tb_uart.sv
// Randomized self-checking bench for uart: a serial-frame reference model predicts received bytes,
// strobe timing and the exact echo waveform on tx.
module tb_uart;
    localparam int CPB     = 32;
    localparam int HALF    = CPB / 2;
    localparam int LAT_MIN = 2 + HALF + 9 * CPB;
    localparam int LAT_MAX = 4 + HALF + 9 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       tx;
    logic [7:0] rx_byte;
    logic       byte_read;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int strobe_cnt = 0;
    int last_br_cyc = 0;
    int hold_bad = 0;
    logic [7:0] model_byte = 8'h00;
    logic       prev_br = 1'b0;
    logic [7:0] exp_rx_q[$];
    logic [7:0] exp_tx_q[$];
    int         start_q[$];

    uart #(.CLK_FREQ(100_000_000), .BAUD(3_125_000)) dut (
        .clk(clk), .rst(rst), .rx(rx), .tx(tx), .rx_byte(rx_byte), .byte_read(byte_read)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one frame; only frames with a good stop bit are expected to be received and echoed.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        if (stop_bit) begin
            exp_rx_q.push_back(b);
            exp_tx_q.push_back(b);
            start_q.push_back(cyc);
        end
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = stop_bit;
        tick(CPB);
        rx = 1'b1;
    endtask

    // Receive-side monitor: byte value, strobe width, latency and holding of rx_byte.
    always @(negedge clk) begin
        if (rst) begin
            model_byte = 8'h00;
            prev_br    = 1'b0;
        end else begin
            if (byte_read === 1'b1) begin
                strobe_cnt++;
                last_br_cyc = cyc;
                check("br_width", int'(prev_br), 0);
                if (exp_rx_q.size() == 0) begin
                    check("rx_spurious", 1, 0);
                end else begin
                    model_byte = exp_rx_q.pop_front();
                    check("rx_byte", int'(rx_byte), int'(model_byte));
                    if (start_q.size() > 0) begin
                        int lat;
                        lat = cyc - start_q.pop_front();
                        check("rx_lat", int'(lat >= LAT_MIN && lat <= LAT_MAX), 1);
                    end
                end
            end else if (rx_byte !== model_byte) begin
                hold_bad++;
            end
            prev_br = byte_read;
        end
    end

    // Echo monitor: every cycle of a frame must carry the predicted level, bits exactly CPB long.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && tx === 1'b0) begin
                check("echo_lat", int'((cyc - last_br_cyc) >= 1 && (cyc - last_br_cyc) <= 2), 1);
                if (exp_tx_q.size() == 0) begin
                    check("tx_spurious", 1, 0);
                    for (int k = 0; k < 11 * CPB && tx !== 1'b1; k++) @(negedge clk);
                end else begin
                    logic [9:0] frame;
                    logic [9:0] got;
                    int bad;
                    bit aborted;
                    frame   = {1'b1, exp_tx_q.pop_front(), 1'b0};
                    got     = '0;
                    bad     = 0;
                    aborted = 1'b0;
                    for (int c = 0; c < 10 * CPB && !aborted; c++) begin
                        if (c > 0) @(negedge clk);
                        if (rst) begin
                            aborted = 1'b1;
                        end else begin
                            if (tx !== frame[c / CPB]) bad++;
                            if (c % CPB == HALF) got[c / CPB] = tx;
                        end
                    end
                    if (aborted) begin
                        exp_tx_q.delete();
                    end else begin
                        check("tx_frame", int'(got), int'(frame));
                        check("tx_stable", bad, 0);
                    end
                end
            end
        end
    end

    initial begin
        int s0;
        logic [7:0] dir [4];
        dir[0] = 8'hAB; dir[1] = 8'hFF; dir[2] = 8'h00; dir[3] = 8'h12;

        tick(4);
        @(negedge clk);
        check("rst_tx", int'(tx), 1);
        check("rst_byte", int'(rx_byte), 0);
        check("rst_br", int'(byte_read), 0);
        tick(1);
        rst = 1'b0;
        tick(3);

        for (int i = 0; i < 4; i++) send_frame(dir[i], 1'b1);
        for (int i = 0; i < 6; i++) send_frame(8'($urandom_range(0, 255)), 1'b1);
        tick(12 * CPB);
        check("b2b_drained", exp_rx_q.size(), 0);

        send_frame(8'h5A, 1'b1);
        tick(12 * CPB);
        check("echo_byte", int'(rx_byte), 8'h5A);

        s0 = strobe_cnt;
        rx = 1'b0;
        tick(8);
        rx = 1'b1;
        tick(4 * CPB);
        check("glitch_strobe", strobe_cnt - s0, 0);
        check("glitch_tx", int'(tx), 1);

        s0 = strobe_cnt;
        send_frame(8'h3C, 1'b0);
        tick(2 * CPB);
        send_frame(8'h81, 1'b1);
        tick(12 * CPB);
        check("fe_strobes", strobe_cnt - s0, 1);
        check("fe_byte", int'(rx_byte), 8'h81);

        // Second frame is cut by reset during its bit 4 while the echo of 0x47 is on tx.
        send_frame(8'h47, 1'b1);
        rx = 1'b0;
        tick(CPB);
        rx = 1'b1;
        tick(4 * CPB + HALF);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_tx", int'(tx), 1);
        tick(3);
        check("rst_mid_byte", int'(rx_byte), 0);
        check("rst_mid_br", int'(byte_read), 0);
        rst = 1'b0;
        tick(4 * CPB);
        s0 = strobe_cnt;
        send_frame(8'hC3, 1'b1);
        tick(12 * CPB);
        check("rst_c3_strobes", strobe_cnt - s0, 1);
        check("rst_c3_byte", int'(rx_byte), 8'hC3);

        for (int i = 0; i < 4; i++) send_frame(8'($urandom_range(0, 255)), 1'b1);
        tick(12 * CPB);

        check("rx_q_empty", exp_rx_q.size(), 0);
        check("tx_q_empty", exp_tx_q.size(), 0);
        check("byte_hold", hold_bad, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
